// File: rtl/rd_burst_tracker.sv
// Outstanding read-burst tracker: in-order queue of {len,tag} per accepted AR,
// R beat counting against the head burst, and sticky RLAST protocol error flags.
module rd_burst_tracker #(
    parameter int DEPTH = 8,
    parameter int LEN_W = 8,
    parameter int TAG_W = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    input  logic [LEN_W-1:0] push_len,
    input  logic [TAG_W-1:0] push_tag,
    output logic             push_ready,
    input  logic             beat_valid,
    input  logic             beat_last,
    output logic [LEN_W-1:0] cur_len,
    output logic [TAG_W-1:0] cur_tag,
    output logic [LEN_W-1:0] cur_beat,
    output logic             exp_last,
    output logic             full_n,
    output logic             empty_n,
    output logic [CNT_W-1:0] count,
    input  logic             err_clr,
    output logic             err_early_last,
    output logic             err_missing_last,
    output logic             err_underflow
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LEN_W-1:0] len_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             empty;
    logic             full;
    logic             at_last;
    logic             push_ok;
    logic             beat_ok;
    logic             retire;
    logic             set_early;
    logic             set_missing;
    logic             set_underflow;

    assign rd_idx = rd_ptr[IDX_W-1:0];
    assign wr_idx = wr_ptr[IDX_W-1:0];

    // The pointer MSB is a wrap flag that disambiguates full from empty.
    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_idx == wr_idx) && (rd_ptr[PTR_W-1] != wr_ptr[PTR_W-1]);

    assign full_n     = !full;
    assign empty_n    = !empty;
    assign push_ready = !full;

    assign cur_len  = empty ? '0 : len_mem[rd_idx];
    assign cur_tag  = empty ? '0 : tag_mem[rd_idx];
    assign at_last  = (cur_beat == cur_len);
    assign exp_last = !empty && at_last;

    // full/empty are sampled before this cycle's retire/push take effect.
    assign push_ok = push_valid && !full;
    assign beat_ok = beat_valid && !empty;
    assign retire  = beat_ok && (beat_last || at_last);

    assign set_early     = beat_ok && beat_last && !at_last;
    assign set_missing   = beat_ok && !beat_last && at_last;
    assign set_underflow = beat_valid && empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                len_mem[i] <= '0;
                tag_mem[i] <= '0;
            end
        end else if (push_ok) begin
            len_mem[wr_idx] <= push_len;
            tag_mem[wr_idx] <= push_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            cur_beat <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (retire) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                cur_beat <= '0;
            end else if (beat_ok) begin
                cur_beat <= cur_beat + LEN_W'(1);
            end
            case ({push_ok, retire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A clear wins over any error detected in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || err_clr) begin
            err_early_last   <= 1'b0;
            err_missing_last <= 1'b0;
            err_underflow    <= 1'b0;
        end else begin
            err_early_last   <= err_early_last   | set_early;
            err_missing_last <= err_missing_last | set_missing;
            err_underflow    <= err_underflow    | set_underflow;
        end
    end

endmodule
